// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// the default bus timeout, and the store-lane/legality helpers used at accept.
// Contents: F3_* encodings, lsu_state_e, LSU_TIMEOUT_DEFAULT, lsu_bad_access,
// lsu_store_be, lsu_store_data.
package lsu_pkg;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  // RV32I load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  // Request is rejected without touching the bus when the width code does not
  // exist for the direction, or the address is not naturally aligned.
  function automatic logic lsu_bad_access(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
    logic illegal;
    logic misaligned;
    if (we) begin
      illegal = (f3 > F3_W);
    end else begin
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    // f3[1:0] == 01 covers both H and HU
    misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                 ((f3 == F3_W) && (off != 2'b00));
    return illegal || misaligned;
  endfunction

  // Byte enables for a store; only called for legal, aligned stores.
  function automatic logic [3:0] lsu_store_be(input logic [1:0] f3_lo,
                                              input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    case (f3_lo)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the byte enables pick the lane.
  function automatic logic [31:0] lsu_store_data(input logic [1:0]  f3_lo,
                                                 input logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    case (f3_lo)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shifts the bus word down by the byte offset and
// sign- or zero-extends according to funct3. Purely combinational, no state.
// Ports: funct3_i (width code), offset_i (addr[1:0]), rdata_i (bus word),
// data_o (register-file value).
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    data_o  = shifted;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'h000000, shifted[7:0]};
      F3_HU:   data_o = {16'h0000, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: RV32I load/store unit bridging a single-request core port to a
//   req/gnt/rvalid memory bus, with alignment, lane steering and timeout.
// Latency: 3 cycles accept-to-rsp_valid with immediate gnt/rvalid; 1 cycle
//   for rejected (misaligned/illegal) requests.
// Backpressure: one transaction in flight; req_ready_o low while busy, the
//   core holds its request; mem_* held stable until mem_gnt_i.
// Ports: clk_i/rst_i; req_* core request; rsp_* completion pulse; busy_o
//   stall; mem_* bus request/response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              timeout_hit;
  logic              bad_access;
  logic [31:0]       load_data;

  lsu_load_align u_align (
    .funct3_i (funct3_q),
    .offset_i (addr_q[1:0]),
    .rdata_i  (mem_rdata_i),
    .data_o   (load_data)
  );

  assign bad_access  = lsu_bad_access(req_we_i, req_funct3_i, req_addr_i[1:0]);
  // The abort cycle itself drops mem_req_o, so a grant in that cycle cannot
  // have been issued against this request.
  assign timeout_hit = ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) &&
                       (cnt_q == CNT_LIMIT);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      LSU_IDLE: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          funct3_d = req_funct3_i;
          we_d     = req_we_i;
          be_d     = req_we_i ? lsu_store_be(req_funct3_i[1:0], req_addr_i[1:0]) : 4'b1111;
          wdata_d  = req_we_i ? lsu_store_data(req_funct3_i[1:0], req_wdata_i) : 32'h0;
          cnt_d    = '0;
          rdata_d  = 32'h0;
          err_d    = bad_access;
          state_d  = bad_access ? LSU_RESP : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = LSU_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (mem_gnt_i) begin
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = LSU_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (mem_rvalid_i) begin
            // Stores complete with zero data; the bus word is meaningless.
            rdata_d = we_q ? 32'h0 : load_data;
            state_d = LSU_RESP;
          end
        end
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= LSU_IDLE;
      addr_q   <= 32'h0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      cnt_q    <= '0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Bus outputs are zero whenever no request is presented.
  assign mem_req_o   = (state_q == LSU_REQ) && !timeout_hit;
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_be_o    = mem_req_o ? be_q : 4'b0000;
  assign mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata_o = mem_req_o ? wdata_q : 32'h0;

  assign req_ready_o = (state_q == LSU_IDLE);
  assign busy_o      = (state_q != LSU_IDLE);
  assign rsp_valid_o = (state_q == LSU_RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'h0;

endmodule
